// File: rtl/replica_scheduler.sv
// Scheduler for a chained replica array: runs iter_count opt steps, cycling the opt
// command, then scans the recirculating total-distance chain for the minimum.
module replica_scheduler #(
  parameter int unsigned replica_num = 32,
  parameter int unsigned dist_w      = 32,
  parameter int unsigned com_max     = 3,
  localparam int unsigned idx_w      = (replica_num > 1) ? $clog2(replica_num) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       iter_count,
  input  logic              step_done,
  output logic              opt_run,
  output logic [1:0]        opt_com,
  output logic              exchange_valid,
  output logic              distance_shift,
  input  logic [dist_w-1:0] distance_rdata,
  output logic [dist_w-1:0] distance_wdata,
  output logic [dist_w-1:0] best_distance,
  output logic [idx_w-1:0]  best_index,
  output logic              busy,
  output logic              done
);

  localparam logic [idx_w-1:0] last_k  = idx_w'(replica_num - 1);
  localparam logic [1:0]       com_top = 2'(com_max);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      iter_target;
  logic [31:0]      iter_cnt;
  logic [31:0]      iter_cnt_inc;
  logic [1:0]       com_idx;
  logic [idx_w-1:0] scan_cnt;
  logic             accept;
  logic             step;
  logic             scan_step;

  logic opt_run_d;
  logic exchange_valid_d;
  logic distance_shift_d;
  logic busy_d;
  logic done_d;

  // The chain only recirculates; it is never rewritten by the scheduler.
  assign distance_wdata = distance_rdata;
  assign opt_com        = com_idx;

  assign iter_cnt_inc = iter_cnt + 32'd1;
  assign accept       = (state == S_IDLE) && start && !abort;
  assign step         = (state == S_WAIT) && step_done && !abort;
  assign scan_step    = (state == S_SCAN) && !abort;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort outranks every other input outside IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = (iter_count == 32'd0) ? S_SCAN : S_RUN;
        end
      end
      S_RUN:  state_next = S_WAIT;
      S_WAIT: begin
        if (step_done) begin
          state_next = (iter_cnt_inc == iter_target) ? S_SCAN : S_RUN;
        end
      end
      S_SCAN: begin
        if (scan_cnt == last_k) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
    end
  end

  // Output decode from the next state so the registered outputs align with the state
  always_comb begin
    opt_run_d        = 1'b0;
    exchange_valid_d = 1'b0;
    distance_shift_d = 1'b0;
    busy_d           = 1'b0;
    done_d           = 1'b0;
    unique case (state_next)
      S_RUN: begin
        opt_run_d        = 1'b1;
        exchange_valid_d = 1'b1;
        busy_d           = 1'b1;
      end
      S_WAIT: begin
        exchange_valid_d = 1'b1;
        busy_d           = 1'b1;
      end
      S_SCAN: begin
        distance_shift_d = 1'b1;
        busy_d           = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opt_run        <= 1'b0;
      exchange_valid <= 1'b0;
      distance_shift <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      opt_run        <= opt_run_d;
      exchange_valid <= exchange_valid_d;
      distance_shift <= distance_shift_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

  // Iteration/command counters and the minimum search over the scanned chain
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_target   <= 32'd0;
      iter_cnt      <= 32'd0;
      com_idx       <= 2'd0;
      scan_cnt      <= '0;
      best_distance <= '0;
      best_index    <= '0;
    end else begin
      if (accept) begin
        iter_target <= iter_count;
        iter_cnt    <= 32'd0;
        com_idx     <= 2'd0;
      end else if (step) begin
        iter_cnt <= iter_cnt_inc;
        com_idx  <= (com_idx == com_top) ? 2'd0 : com_idx + 2'd1;
      end

      if (scan_step) begin
        scan_cnt <= scan_cnt + idx_w'(1);
        // Sample k belongs to replica replica_num-1-k; ties keep the higher id
        if ((scan_cnt == '0) || (distance_rdata < best_distance)) begin
          best_distance <= distance_rdata;
          best_index    <= last_k - scan_cnt;
        end
      end else begin
        scan_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_replica_scheduler.sv
// Directed-plus-random bench for replica_scheduler with a behavioural chain,
// a step_done responder and a min-search reference model.
module tb_replica_scheduler;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int COM_MAX = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [31:0]   iter_count;
  logic          step_done;
  logic          opt_run;
  logic [1:0]    opt_com;
  logic          exchange_valid;
  logic          distance_shift;
  logic [DW-1:0] distance_rdata;
  logic [DW-1:0] distance_wdata;
  logic [DW-1:0] best_distance;
  logic [4:0]    best_index;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  int orun_cnt  = 0;
  int shift_cnt = 0;
  int done_cnt  = 0;
  int cd        = 0;
  logic [1:0]    com_log[$];
  logic [DW-1:0] pos[N];
  logic [DW-1:0] orig[N];

  replica_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .iter_count(iter_count), .step_done(step_done), .opt_run(opt_run),
    .opt_com(opt_com), .exchange_valid(exchange_valid),
    .distance_shift(distance_shift), .distance_rdata(distance_rdata),
    .distance_wdata(distance_wdata), .best_distance(best_distance),
    .best_index(best_index), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Node-array chain model: head is pos[N-1], wdata enters at pos[0]
  assign distance_rdata = pos[N-1];
  always @(posedge clk) begin
    if (distance_shift) begin
      pos[0] <= distance_wdata;
      for (int i = 1; i < N; i++) pos[i] <= pos[i-1];
    end
  end

  // Monitor and step_done responder (answers each opt_run two cycles later)
  initial begin
    step_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (opt_run) begin
        orun_cnt++;
        com_log.push_back(opt_com);
      end
      if (distance_shift) shift_cnt++;
      if (done) done_cnt++;
      if (opt_run) cd = 3;
      else if (cd > 0) cd--;
      step_done = (cd == 1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    orun_cnt  = 0;
    shift_cnt = 0;
    done_cnt  = 0;
    com_log.delete();
  endtask

  // mode 0: random, 1: 1000-i with id 7 = 3, 2: all 50
  task automatic load_chain(input int mode);
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       v = DW'($urandom);
        1:       v = (i == 7) ? DW'(3) : DW'(1000 - i);
        default: v = DW'(50);
      endcase
      orig[i] = v;
      pos[i] <= v;
    end
    @(negedge clk);
  endtask

  task automatic ref_best(output logic [DW-1:0] mv, output int mi);
    mv = '1;
    mi = 0;
    for (int i = 0; i < N; i++) begin
      if (orig[i] <= mv) begin
        mv = orig[i];
        mi = i;
      end
    end
  endtask

  task automatic check_chain(input string tag);
    int diff = 0;
    for (int i = 0; i < N; i++) if (pos[i] !== orig[i]) diff++;
    check(tag, 64'(diff), 64'd0);
  endtask

  task automatic run(input logic [31:0] iters, input int budget, input string tag);
    clear_mon();
    iter_count = iters;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget && !(done_cnt > 0 && busy == 1'b0); c++) @(negedge clk);
    check({tag, "_finished"}, 64'(done_cnt > 0 && busy == 1'b0), 64'd1);
  endtask

  logic [DW-1:0] mv;
  int mi;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; iter_count = 32'd0;
    load_chain(2);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_opt_run", 64'(opt_run), 64'd0);
    check("rst_opt_com", 64'(opt_com), 64'd0);
    check("rst_exch", 64'(exchange_valid), 64'd0);
    check("rst_shift", 64'(distance_shift), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_best", 64'({best_distance, best_index}), 64'd0);

    // Five opt steps with command cycling, then a full scan of a random chain
    load_chain(0);
    run(32'd5, 600, "iter5");
    check("iter5_orun", 64'(orun_cnt), 64'd5);
    for (int i = 0; i < 5; i++)
      check("iter5_com", 64'((i < com_log.size()) ? com_log[i] : 2'bxx), 64'(i % (COM_MAX + 1)));
    check("iter5_shift", 64'(shift_cnt), 64'(N));
    check("iter5_done", 64'(done_cnt), 64'd1);
    ref_best(mv, mi);
    check("iter5_bestd", 64'(best_distance), 64'(mv));
    check("iter5_besti", 64'(best_index), 64'(mi));
    check_chain("iter5_chain");

    // Scan only, single low outlier
    load_chain(1);
    run(32'd0, 200, "scan0");
    check("scan0_orun", 64'(orun_cnt), 64'd0);
    check("scan0_bestd", 64'(best_distance), 64'd3);
    check("scan0_besti", 64'(best_index), 64'd7);
    check_chain("scan0_chain");

    // All equal: tie keeps highest id
    load_chain(2);
    run(32'd0, 200, "tie");
    check("tie_bestd", 64'(best_distance), 64'd50);
    check("tie_besti", 64'(best_index), 64'(N - 1));
    check("tie_done", 64'(done_cnt), 64'd1);

    // Abort together with start in IDLE stays idle
    clear_mon();
    iter_count = 32'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abst_busy", 64'(busy), 64'd0);
    check("abst_orun", 64'(orun_cnt), 64'd0);

    // Abort in the third WAIT
    clear_mon();
    iter_count = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && orun_cnt < 3; c++) @(negedge clk);
    check("abort_reach", 64'(orun_cnt), 64'd3);
    @(negedge clk);
    check("abort_in_wait", 64'({exchange_valid, opt_run}), 64'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 64'({busy, exchange_valid, opt_run, distance_shift}), 64'd0);
    repeat (20) @(negedge clk);
    check("abort_orun", 64'(orun_cnt), 64'd3);
    check("abort_done", 64'(done_cnt), 64'd0);
    check("abort_shift", 64'(shift_cnt), 64'd0);
    check("abort_best", 64'({best_distance, best_index}), 64'({32'd50, 5'd31}));

    // Reset at scan step k=10
    load_chain(0);
    clear_mon();
    iter_count = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && shift_cnt < 11; c++) @(negedge clk);
    check("rst_scan_reach", 64'(shift_cnt), 64'd11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstscan_ctl", 64'({opt_run, opt_com, exchange_valid, distance_shift, busy, done}), 64'd0);
    check("rstscan_best", 64'({best_distance, best_index}), 64'd0);
    load_chain(0);
    run(32'd2, 400, "postrst");
    check("postrst_orun", 64'(orun_cnt), 64'd2);
    ref_best(mv, mi);
    check("postrst_best", 64'({best_distance, best_index}), 64'({mv, 5'(mi)}));

    // Start held while busy is ignored; exactly one done
    load_chain(0);
    clear_mon();
    iter_count = 32'd3; start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 400 && !(done_cnt > 0 && busy == 1'b0); c++) begin
      start = busy;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("nostack_done", 64'(done_cnt), 64'd1);
    check("nostack_orun", 64'(orun_cnt), 64'd3);
    check("nostack_busy", 64'(busy), 64'd0);
    ref_best(mv, mi);
    check("nostack_best", 64'({best_distance, best_index}), 64'({mv, 5'(mi)}));
    check_chain("nostack_chain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/replica_scheduler.md
REPLICA_SCHEDULER -- requirements
Module: replica_scheduler

Interface
REQ-001 Parameter replica_num, default 32: number of replica nodes in the chained array.
REQ-002 Parameter dist_w, default 32: width of one total-distance word (total_data_t).
REQ-003 Parameter com_max, default 3: highest opt_com value cycled through; 2 bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 abort  input  1  one-cycle request to terminate the current run.
REQ-008 iter_count  input  32  number of opt steps per run; sampled on accepted start.
REQ-009 step_done  input  1  one-cycle pulse from the node array marking end of the current opt step.
REQ-010 opt_run  output  1  one-cycle pulse launching an opt step.
REQ-011 opt_com  output  2  opt command for the step; held stable from opt_run until step_done.
REQ-012 exchange_valid  output  1  high while optimisation steps are in progress.
REQ-013 distance_shift  output  1  shifts the total-distance chain one position.
REQ-014 distance_rdata  input  dist_w  chain output word.
REQ-015 distance_wdata  output  dist_w  chain input word; always equals distance_rdata (recirculation).
REQ-016 best_distance  output  dist_w  minimum total distance found by the last scan.
REQ-017 best_index  output  $clog2(replica_num)  replica id holding best_distance.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on completion of a run.

Function
REQ-020 States: IDLE, RUN, WAIT, SCAN, DONE.
REQ-021 IDLE: start=1 and iter_count!=0 -> RUN; start=1 and iter_count=0 -> SCAN; iteration counter and com index cleared to 0.
REQ-022 RUN: opt_run=1 for exactly one cycle, opt_com = com index; next state WAIT.
REQ-023 WAIT: opt_run=0; on step_done: iteration counter +1, com index +1 wrapping from com_max to 0; if new count = sampled iter_count -> SCAN, else -> RUN.
REQ-024 step_done in any state other than WAIT is ignored.
REQ-025 exchange_valid = 1 in RUN and WAIT only.
REQ-026 SCAN: distance_shift=1 for exactly replica_num consecutive cycles; scan counter k = 0..replica_num-1.
REQ-027 In each SCAN cycle distance_rdata is sampled; sample k corresponds to replica id replica_num-1-k.
REQ-028 k=0 loads best_distance/best_index unconditionally; k>0 updates only if sample is strictly less than best_distance (ties keep earlier sample, i.e. higher id).
REQ-029 Distance comparison is unsigned, dist_w bits.
REQ-030 After the k=replica_num-1 cycle -> DONE; DONE asserts done for one cycle, then -> IDLE.
REQ-031 After a complete scan the chain holds its original order (full recirculation).
REQ-032 best_distance/best_index hold their values in IDLE until the next scan starts.
REQ-033 start while busy is ignored; it does not queue.
REQ-034 abort in any non-IDLE state: next cycle IDLE, opt_run/exchange_valid/distance_shift=0, no done pulse, best_* unchanged if abort precedes SCAN, else undefined-but-stable.
REQ-035 abort and start in the same IDLE cycle: abort wins, stay IDLE.
REQ-036 abort and step_done in the same cycle: abort wins.
REQ-037 Iteration counter 32 bits, no wrap possible since it stops at iter_count.

Reset
REQ-038 reset takes priority over all inputs, including mid-run: state IDLE next cycle.
REQ-039 Reset values: opt_run=0, opt_com=0, exchange_valid=0, distance_shift=0, busy=0, done=0, best_distance=0, best_index=0, counters=0.

Verification
REQ-040 iter_count=5, step_done 3 cycles after each opt_run -> 5 opt_run pulses, opt_com 0,1,2,3,0, then 32 distance_shift cycles, done once.
REQ-041 iter_count=0, chain values id i = 1000-i except id 7 = 3 -> no opt_run, best_distance=3, best_index=7, chain unchanged after scan.
REQ-042 Chain all values 50 -> best_distance=50, best_index=31 (tie rule).
REQ-043 abort during 3rd WAIT -> IDLE next cycle, exactly 3 opt_run seen, no done, no distance_shift.
REQ-044 reset asserted mid-SCAN (k=10) -> all outputs at reset values next cycle; subsequent start runs normally.
REQ-045 start pulsed during RUN/WAIT/SCAN -> ignored; only one done per accepted start.
